// File: rtl/im_prefetch.sv
// Instruction prefetch queue: walks a fetch PC, issues single-word reads over a
// req/ack handshake, buffers returned words with PC+4 and presents the head.
module im_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic [31:0] inst,
    output logic [31:0] inst_pc4,
    output logic        inst_valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_inst_q [DEPTH];
    logic [31:0]        fifo_inst_d [DEPTH];
    logic [31:0]        fifo_pc4_q  [DEPTH];
    logic [31:0]        fifo_pc4_d  [DEPTH];

    logic               push;
    logic               pop;
    logic               space;
    logic [CNT_W-1:0]   count_nxt;

    assign mem_req    = (state_q == WAIT) || (state_q == DISCARD);
    assign mem_addr   = mem_req ? addr_q : fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;
    assign inst_pc4   = inst_valid ? fifo_pc4_q[rd_ptr_q]  : 32'd0;

    // Next-state, FIFO bookkeeping and fetch address update
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_inst_d = fifo_inst_q;
        fifo_pc4_d  = fifo_pc4_q;

        pop       = inst_valid && !hold && !redirect;
        push      = (state_q == WAIT) && mem_ack && !redirect;
        count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
        space     = (count_nxt < CNT_W'(DEPTH));
        count_d   = count_nxt;

        if (push) begin
            fifo_inst_d[wr_ptr_q] = mem_data;
            fifo_pc4_d[wr_ptr_q]  = addr_q + 32'd4;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            fetch_pc_d            = fetch_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!redirect && space) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack) begin
                    if (space) begin
                        addr_d = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                // The stale request completes here; its data never enters the queue
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_inst_q[i] <= 32'd0;
                fifo_pc4_q[i]  <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            addr_q      <= addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc4_q  <= fifo_pc4_d;
        end
    end

endmodule

// File: tb/tb_im_prefetch.sv
// Directed bench for im_prefetch: table-driven zero-wait stream plus
// hand-written fill/hold, discard, and mid-operation reset sequences.
module tb_im_prefetch;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;
    logic [31:0] inst;
    logic [31:0] inst_pc4;
    logic        inst_valid;

    int tests_run;
    int tests_failed;

    // memory model: acks once a request has been high for lat cycles
    int   lat;
    int   wait_cnt;
    logic mem_en;
    logic ack_force;

    im_prefetch #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hold        (hold),
        .inst        (inst),
        .inst_pc4    (inst_pc4),
        .inst_valid  (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack  = ack_force | (mem_en & mem_req & (wait_cnt == lat));
    assign mem_data = mem_addr;

    always @(posedge clk or posedge reset) begin
        if (reset)                  wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                        wait_cnt <= 0;
    end

    typedef struct {
        logic        hold;
        logic        redirect;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] ins, input logic [31:0] pc4);
        check({name, " req"},      32'(mem_req),    32'(req));
        check({name, " addr"},     mem_addr,        addr);
        check({name, " valid"},    32'(inst_valid), 32'(valid));
        check({name, " inst"},     inst,            ins);
        check({name, " inst_pc4"}, inst_pc4,        pc4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        hold         = 1'b0;
        lat          = 0;
        mem_en       = 1'b1;
        ack_force    = 1'b0;

        //                hold  redir rpc       req   addr      valid inst      pc4
        vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h00, 32'h04};
        vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 1'b1, 32'h04, 32'h08};
        vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h0C};
        vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h10};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h14, 1'b1, 32'h10, 32'h14};
        vecs[6]  = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h40, 1'b0, 32'h00, 32'h00};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h40, 1'b0, 32'h00, 32'h00};
        vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h44, 1'b1, 32'h40, 32'h44};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h48, 1'b1, 32'h40, 32'h44};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4C, 1'b1, 32'h40, 32'h44};
        vecs[11] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h50, 1'b1, 32'h40, 32'h44};
        vecs[12] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h50, 1'b1, 32'h40, 32'h44};
        vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h50, 1'b1, 32'h44, 32'h48};
        vecs[14] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h54, 1'b1, 32'h48, 32'h4C};

        // Reset state
        #2 reset = 1'b1;
        #1;
        check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Zero-wait stream, redirect with simultaneous ack, then fill under hold
        do_reset();
        lat = 0;
        for (int i = 0; i < 15; i++) begin
            hold        = vecs[i].hold;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            step();
            check_out($sformatf("zw[%0d]", i), vecs[i].exp_req, vecs[i].exp_addr,
                      vecs[i].exp_valid, vecs[i].exp_inst, vecs[i].exp_pc4);
        end
        redirect = 1'b0;
        hold     = 1'b0;

        // Fill and hold with 1-cycle latency memory
        lat  = 1;
        hold = 1'b1;
        do_reset();
        repeat (10) step();
        check_out("fill_full", 1'b0, 32'h10, 1'b1, 32'h00, 32'h04);
        hold = 1'b0;
        step();
        check_out("fill_rel0", 1'b1, 32'h10, 1'b1, 32'h04, 32'h08);
        for (int k = 1; k < 4; k++) begin
            step();
            check($sformatf("fill_rel%0d inst", k), inst, 32'(4 * (k + 1)));
            check($sformatf("fill_rel%0d pc4", k), inst_pc4, 32'(4 * (k + 2)));
        end

        // Redirect during an outstanding 3-cycle read
        lat  = 2;
        hold = 1'b0;
        do_reset();
        step();
        check_out("disc_issue", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        check_out("disc_hold", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("disc_stale_ack", 32'(mem_ack), 32'h1);
        check("disc_stale_addr", mem_addr, 32'h0);
        step();
        check_out("disc_idle", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        step();
        check_out("disc_reissue", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        repeat (2) begin
            step();
            check("disc_wait valid", 32'(inst_valid), 32'h0);
        end
        step();
        check_out("disc_data", 1'b1, 32'h104, 1'b1, 32'h100, 32'h104);

        // Reset mid-operation in WAIT with two entries queued
        lat  = 2;
        hold = 1'b1;
        do_reset();
        repeat (7) step();
        check_out("mid_pre", 1'b1, 32'h08, 1'b1, 32'h00, 32'h04);
        #2 reset = 1'b1;
        #1;
        check_out("mid_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        hold = 1'b0;
        @(posedge clk);
        #1;
        mem_en    = 1'b0;
        ack_force = 1'b1;
        reset     = 1'b0;
        step();
        ack_force = 1'b0;
        mem_en    = 1'b1;
        check_out("mid_restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (2) step();
        check("mid_noack valid", 32'(inst_valid), 32'h0);
        step();
        check_out("mid_first", 1'b1, 32'h04, 1'b1, 32'h00, 32'h04);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/im_prefetch.md
# im_prefetch

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register of the five-stage MIPS core. It walks a fetch PC and issues single-word reads to a variable-latency instruction memory using a req/ack handshake. It buffers up to DEPTH returned words with their PC+4, and presents the head word to the pipeline. Branch and jump redirects flush the queue and drop any in-flight return.

## Interface
- DEPTH, 4: queue entries; a power of two, at least 2.
- RESET_PC, 32'd0: fetch address after reset.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  32  word-aligned read address; stable while mem_req is high.
- mem_ack  in  1  one-cycle acknowledge; mem_data is valid in the same cycle.
- mem_data  in  32  returned instruction word.
- redirect  in  1  taken branch or jump (pcsrc | jump_s4, or the stage-2 branch).
- redirect_pc  in  32  new fetch address; sampled when redirect is high.
- hold  in  1  pipeline stall (stall_s1_s2); head is not consumed.
- inst  out  32  head instruction; 32'd0 (nop) when the queue is empty.
- inst_pc4  out  32  head PC+4; 32'd0 when the queue is empty.
- inst_valid  out  1  queue is non-empty.

## Operation
- State: fetch_pc (32), DEPTH-entry FIFO of {inst, pc4}, rd_ptr, wr_ptr, count (0..DEPTH), and an FSM with states IDLE, WAIT, DISCARD.
- Outputs:
  - mem_req = (state == WAIT || state == DISCARD).
  - mem_addr = the registered address of the request in flight; otherwise fetch_pc.
- pop = inst_valid & ~hold & ~redirect.
- push = (state == WAIT) & mem_ack & ~redirect. On push, write {mem_data, addr+4} and advance fetch_pc by 4 (32-bit wrap).
- space = (count + push − pop) < DEPTH.
- IDLE:
  - redirect → IDLE, with fetch_pc = redirect_pc.
  - space → WAIT, latching mem_addr = fetch_pc.
  - otherwise stay in IDLE.
- WAIT:
  - redirect & ~mem_ack → DISCARD.
  - redirect & mem_ack → IDLE; the data is dropped.
  - mem_ack & space → WAIT, latching the next address (back-to-back issue).
  - mem_ack & ~space → IDLE.
  - otherwise stay in WAIT.
- DISCARD: the in-flight request cannot be cancelled, and mem_addr stays stable.
  - mem_ack → IDLE; the data is dropped and nothing is pushed.
  - A further redirect while in DISCARD only updates fetch_pc.
- Redirect, in any state:
  - count, rd_ptr and wr_ptr clear at the same edge.
  - fetch_pc loads redirect_pc.
  - Redirect has priority over push and pop.
- Full (count == DEPTH): no new request is issued; a pending request always has a reserved slot, so push never overflows.
- Empty: inst and inst_pc4 read 0 so the pipeline sees a nop bubble. A pop while empty is impossible because pop is gated by inst_valid.
- Reset, asynchronous and allowed mid-transaction:
  - state = IDLE, count = 0, pointers = 0.
  - fetch_pc = RESET_PC, mem_addr = RESET_PC.
  - mem_req = 0, inst_valid = 0, inst = 0, inst_pc4 = 0.
  - An ack arriving after reset in IDLE is ignored.
- mem_data is never forwarded combinationally to inst; the FIFO is the only path.

## Timing
- First request: mem_req rises after the first posedge following reset deassertion, with mem_addr = RESET_PC.
- Zero-wait memory (mem_ack in the same cycle as mem_req):
  - One word is pushed per cycle.
  - inst_valid rises one cycle after the first ack.
  - Steady throughput is 1 instruction per clock when hold is low.
- Fetch-to-issue latency is ack cycle + 1 edge.
- A redirect at edge E gives:
  - inst_valid = 0 after E.
  - A request to redirect_pc at E+1 if no request was outstanding; otherwise one cycle after the pending ack.
- Head changes only on pop or redirect edges; it is stable for the whole cycle otherwise.

## Test plan
- Zero-wait stream: reset, RESET_PC = 0, mem_ack tied to mem_req, mem_data = addr → inst sequence 0, 4, 8, … with inst_pc4 = 4, 8, 12; inst_valid continuous from the second cycle after the first ack.
- Fill and hold: 1-cycle-latency memory, hold = 1 for 10 cycles → count reaches 4, mem_req drops to 0; release hold → instructions 0 … 0xC emerge in order and fetching resumes at 0x10.
- Redirect while idle or full: full queue, redirect_pc = 0x40 → inst_valid 0 next cycle, next mem_addr = 0x40, then inst = word at 0x40 with inst_pc4 = 0x44.
- Redirect during outstanding read: 3-cycle latency, redirect to 0x100 in the first wait cycle → the stale word is never presented; the next request is 0x100, issued one cycle after the stale ack.
- Simultaneous redirect and ack: redirect and mem_ack in the same cycle → ack data dropped, pop suppressed, next mem_addr = redirect_pc.
- Reset mid-operation: assert reset while in WAIT with count = 2 → all outputs immediately take reset values; after release, fetch restarts at RESET_PC.
